// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction
// memory address, and loads the IF/ID pipeline register. It handles decode
// stalls and taken-branch redirects, flushing the wrong-path instruction.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    input  logic [31:0] IMEM_INST,
    output logic [31:0] IMEM_ADDR,
    output logic [31:0] IFID_INST,
    output logic [31:0] IFID_PC4,
    output logic        IFID_VALID,
    output logic [31:0] FETCH_CNT
);

    localparam int unsigned XLEN     = 32;
    localparam int unsigned PC_STEP  = 4;
    localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

    logic [XLEN-1:0] pc_q,        pc_d;
    logic [XLEN-1:0] ifid_inst_q, ifid_inst_d;
    logic [XLEN-1:0] ifid_pc4_q,  ifid_pc4_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;

    logic [XLEN-1:0] pc_plus4_c;

    // Byte-offset bits of the branch target are discarded: the PC stays word aligned.
    logic            unused_redirect_lsb;
    assign unused_redirect_lsb = ^REDIRECT_PC[1:0];

    // Sequential fall-through address, wraps modulo 2^32.
    assign pc_plus4_c = pc_q + XLEN'(PC_STEP);

    // Next-state selection: redirect beats stall beats normal fetch.
    always_comb begin
        pc_d         = pc_q;
        ifid_inst_d  = ifid_inst_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        fetch_cnt_d  = fetch_cnt_q;

        if (REDIRECT) begin
            // Jump to the target and squash the word fetched on the wrong path.
            pc_d         = {REDIRECT_PC[XLEN-1:2], 2'b00};
            ifid_inst_d  = NOP_INST;
            ifid_pc4_d   = '0;
            ifid_valid_d = 1'b0;
        end else if (!STALL) begin
            pc_d         = pc_plus4_c;
            ifid_inst_d  = IMEM_INST;
            ifid_pc4_d   = pc_plus4_c;
            ifid_valid_d = 1'b1;
            fetch_cnt_d  = fetch_cnt_q + XLEN'(1);
        end
    end

    // PC and IF/ID register with asynchronous reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc_q         <= RESET_PC_ALIGNED;
            ifid_inst_q  <= NOP_INST;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
            fetch_cnt_q  <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

    assign IMEM_ADDR  = pc_q;
    assign IFID_INST  = ifid_inst_q;
    assign IFID_PC4   = ifid_pc4_q;
    assign IFID_VALID = ifid_valid_q;
    assign FETCH_CNT  = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus randomized stall/redirect
// traffic, checked every cycle against a behavioural model of the fetch stage.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        STALL;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic [31:0] IMEM_INST;
    logic [31:0] IMEM_ADDR;
    logic [31:0] IFID_INST;
    logic [31:0] IFID_PC4;
    logic        IFID_VALID;
    logic [31:0] FETCH_CNT;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state.
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic [31:0] m_cnt;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0000)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .STALL       (STALL),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .IMEM_INST   (IMEM_INST),
        .IMEM_ADDR   (IMEM_ADDR),
        .IFID_INST   (IFID_INST),
        .IFID_PC4    (IFID_PC4),
        .IFID_VALID  (IFID_VALID),
        .FETCH_CNT   (FETCH_CNT)
    );

    always #5 CLK = ~CLK;

    // Instruction memory contents: three fixed words at the bottom, hashed elsewhere.
    function automatic logic [31:0] imem(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: imem = 32'hAC00_0064;
            32'h0000_0004: imem = 32'hAC80_0064;
            32'h0000_0008: imem = 32'h8C07_0064;
            default:       imem = (addr * 32'h9E37_79B1) ^ 32'h1234_ABCD;
        endcase
    endfunction

    assign IMEM_INST = imem(IMEM_ADDR);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("imem_addr",  IMEM_ADDR, m_pc);
        chk("ifid_inst",  IFID_INST, m_inst);
        chk("ifid_pc4",   IFID_PC4,  m_pc4);
        chk("ifid_valid", 32'(IFID_VALID), 32'(m_valid));
        chk("fetch_cnt",  FETCH_CNT, m_cnt);
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
    endtask

    // One clock: drive controls, advance the model, compare on the falling edge.
    task automatic step(input logic s, input logic r, input logic [31:0] rpc);
        logic [31:0] word;
        STALL = s; REDIRECT = r; REDIRECT_PC = rpc;
        word = imem(m_pc);
        @(posedge CLK);
        if (r) begin
            m_pc = rpc & 32'hFFFF_FFFC;
            m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (!s) begin
            m_inst = word;
            m_pc = m_pc + 32'd4;
            m_pc4 = m_pc;
            m_valid = 1'b1;
            m_cnt = m_cnt + 32'd1;
        end
        @(negedge CLK);
        check_model();
    endtask

    initial begin
        RESET = 1'b1; STALL = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = 32'h0;
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_model();
        RESET = 1'b0;

        // Straight-line fetch of the first three words.
        step(0, 0, 0);
        chk("lit_inst_e1", IFID_INST, 32'hAC00_0064);
        chk("lit_addr_e1", IMEM_ADDR, 32'd4);
        step(0, 0, 0);
        chk("lit_inst_e2", IFID_INST, 32'hAC80_0064);
        step(0, 0, 0);
        chk("lit_inst_e3", IFID_INST, 32'h8C07_0064);
        chk("lit_pc4_e3",  IFID_PC4,  32'd12);
        chk("lit_cnt_e3",  FETCH_CNT, 32'd3);
        chk("lit_addr_e3", IMEM_ADDR, 32'd12);

        // Two-cycle stall at PC=16.
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("lit_stall_addr", IMEM_ADDR, 32'd16);
        chk("lit_stall_cnt",  FETCH_CNT, 32'd4);
        step(0, 0, 0);
        chk("lit_post_stall_addr", IMEM_ADDR, 32'd20);
        chk("lit_post_stall_pc4",  IFID_PC4,  32'd20);

        // Taken branch at PC=32 back to 16: one bubble.
        step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
        chk("lit_pc_before_br", IMEM_ADDR, 32'd32);
        step(0, 1, 32'd16);
        chk("lit_br_addr",  IMEM_ADDR, 32'd16);
        chk("lit_br_inst",  IFID_INST, 32'h0);
        chk("lit_br_valid", 32'(IFID_VALID), 32'd0);
        chk("lit_br_cnt",   FETCH_CNT, 32'd8);
        step(0, 0, 0);
        chk("lit_tgt_pc4",   IFID_PC4, 32'd20);
        chk("lit_tgt_valid", 32'(IFID_VALID), 32'd1);
        chk("lit_tgt_cnt",   FETCH_CNT, 32'd9);

        // Redirect wins over stall; target low bits dropped.
        step(1, 1, 32'h0000_001B);
        chk("lit_both_addr",  IMEM_ADDR, 32'h0000_0018);
        chk("lit_both_valid", 32'(IFID_VALID), 32'd0);

        // PC wrap at the top of the address space.
        step(0, 1, 32'hFFFF_FFFF);
        chk("lit_top_addr", IMEM_ADDR, 32'hFFFF_FFFC);
        step(0, 0, 0);
        chk("lit_wrap_addr",  IMEM_ADDR, 32'h0);
        chk("lit_wrap_pc4",   IFID_PC4,  32'h0);
        chk("lit_wrap_valid", 32'(IFID_VALID), 32'd1);

        // Randomized stall/redirect traffic.
        for (int i = 0; i < 400; i++) begin
            logic s, r;
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 7) == 0);
            step(s, r, $urandom());
        end

        // Asynchronous reset taken between edges.
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        repeat (5) step(0, 0, 0);
        chk("lit_pre_rst_cnt",   FETCH_CNT, 32'd5);
        chk("lit_pre_rst_valid", 32'(IFID_VALID), 32'd1);
        #2 RESET = 1'b1;
        #1;
        model_reset();
        chk("lit_arst_addr",  IMEM_ADDR, 32'h0);
        chk("lit_arst_inst",  IFID_INST, 32'h0);
        chk("lit_arst_pc4",   IFID_PC4,  32'h0);
        chk("lit_arst_valid", 32'(IFID_VALID), 32'd0);
        chk("lit_arst_cnt",   FETCH_CNT, 32'h0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_model();
        RESET = 1'b0;
        step(0, 0, 0);
        chk("lit_after_rst_inst", IFID_INST, 32'hAC00_0064);
        chk("lit_after_rst_cnt",  FETCH_CNT, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
